ethernet_request_receiver: RTL and testbench
============================================

ETHERNET_REQUEST_RECEIVER -- requirements
Module: ethernet_request_receiver

Interface
REQ-001 Parameter LOCAL_MAC, default 48'h020000000001, station MAC address.
REQ-002 Parameter LOCAL_IP, default 32'hC0A80164, station IPv4 address (192.168.1.100).
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_axis_tvalid / rx_axis_tdata / rx_axis_tlast / rx_axis_tkeep  input  1/64/1/8  MAC receive stream; byte lane 0 (tdata[7:0]) is first wire byte; no tready.
REQ-006 data_head  output  336  frame bytes 0..41; byte 0 in bits [335:328], byte 41 in [7:0].
REQ-007 data_head_frame_payload  output  48  frame bytes 42..47; byte 42 in [7:0], byte 47 in [47:40].
REQ-008 data_head_frame_payload_keep  output  6  rx_axis_tkeep[7:2] of beat 5.
REQ-009 data_head_valid  output  1  one-cycle pulse: header fields valid.
REQ-010 arp_valid / icmp_valid / udp_valid  output  1 each  frame class, level.
REQ-011 m_axis_tvalid / m_axis_tdata / m_axis_tlast / m_axis_tkeep  output  1/64/1/8  payload beats 6.. of accepted frames.
REQ-012 stat_rx_frames / stat_rx_dropped  output  16 each  counters (see Configuration).

Function
REQ-013 Beat k (k = 0..) of a frame holds bytes 8k..8k+7; beat counter advances only on rx_axis_tvalid=1; idle cycles hold all state.
REQ-014 FSM states: IDLE, HEAD, PAYLOAD, DROP; IDLE->HEAD on valid beat 0 with tlast=0.
REQ-015 HEAD captures beats 0..4 fully and beat 5 lanes 0..1 into data_head, lanes 2..7 into data_head_frame_payload.
REQ-016 tlast on beats 0..4 -> frame is runt: no data_head_valid, classes stay 0, return to IDLE, count drop.
REQ-017 Classification on beat 5: dest MAC (bytes 0..5) equals LOCAL_MAC or FF:FF:FF:FF:FF:FF, and one of:
REQ-018  ARP: ethertype 0x0806, opcode bytes 20..21 = 0x0001, target IP bytes 38..41 = LOCAL_IP.
REQ-019  ICMP: ethertype 0x0800, byte 14 = 0x45, protocol byte 23 = 0x01, dest IP bytes 30..33 = LOCAL_IP, type byte 34 = 0x08.
REQ-020  UDP: same IPv4 checks with protocol 0x11, type byte ignored.
REQ-021 Matching frame: data_head_valid pulses exactly one cycle after beat 5 accepted; matching class flag rises same cycle; at most one flag high.
REQ-022 Class flags held until next frame beat 0 accepted, then cleared on that beat's edge.
REQ-023 Non-matching frame: no pulse, flags 0, go to DROP (or IDLE if beat 5 tlast=1), count drop.
REQ-024 Beat 5 tlast=1 on match -> IDLE, no m_axis output.
REQ-025 PAYLOAD: each accepted beat >=6 forwarded on m_axis with 1-cycle latency, tdata/tkeep/tlast copied; m_axis_tvalid=0 otherwise; m_axis_tdata=0 when not valid.
REQ-026 tlast in PAYLOAD or DROP -> IDLE; valid beat in IDLE next cycle starts a new frame (back-to-back, zero gap supported).
REQ-027 data_head and frame_payload hold last captured value until overwritten by next frame's capture.

Reset
REQ-028 i_reset_n=0 asynchronously forces FSM IDLE, beat counter 0, all outputs and counters 0.
REQ-029 Reset mid-frame discards the frame; after release, first valid beat is treated as beat 0.

Configuration
REQ-030 Macro ETH_RX_STATS_EN: defined -> stat_rx_frames increments once per matched frame, stat_rx_dropped once per runt/non-matching frame, both saturating at 16'hFFFF; undefined -> both ports tied to 0, no counter logic.

Verification
REQ-031 ICMP echo request to LOCAL_IP/LOCAL_MAC, 98 bytes (13 beats, last tkeep 8'h03) -> data_head_valid 1 cycle after beat 5, icmp_valid=1, 7 m_axis beats, last tkeep 8'h03 with tlast.
REQ-032 Broadcast ARP request, target IP LOCAL_IP, 64-byte frame -> arp_valid=1, data_head byte 12..13 = 0x0806, 2 m_axis beats.
REQ-033 UDP to wrong IP 192.168.1.7 -> no pulse, flags 0, no m_axis, stat_rx_dropped=1 (macro on).
REQ-034 Runt: tlast on beat 3 then valid ICMP frame back-to-back -> runt dropped, second frame icmp_valid=1.
REQ-035 ICMP frame with tvalid deasserted 3 cycles between beats 2 and 3 -> identical data_head to gap-free case.
REQ-036 Reset asserted at beat 7 of UDP frame -> all outputs 0 immediately; next frame classified correctly.

Source files
------------

// File: rtl/ethernet_request_receiver_if.sv
// rtl/ethernet_request_receiver_if.sv - 64-bit byte-keep stream bundle shared by rx input and payload output
interface ethernet_request_receiver_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;

  modport master (output tvalid, tdata, tlast, tkeep);
  modport slave  (input  tvalid, tdata, tlast, tkeep);
endinterface

// File: rtl/ethernet_request_receiver.sv
// rtl/ethernet_request_receiver.sv - header capture, ARP/ICMP/UDP classification and payload forwarding
// Optional frame/drop counters are built only when ETH_RX_STATS_EN is defined.
module ethernet_request_receiver #(
  parameter logic [47:0] LOCAL_MAC = 48'h020000000001,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A80164
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  ethernet_request_receiver_if.slave         rx_axis,
  output logic [335:0]                       data_head,
  output logic [47:0]                        data_head_frame_payload,
  output logic [5:0]                         data_head_frame_payload_keep,
  output logic                               data_head_valid,
  output logic                               arp_valid,
  output logic                               icmp_valid,
  output logic                               udp_valid,
  ethernet_request_receiver_if.master        m_axis,
  output logic [15:0]                        stat_rx_frames,
  output logic [15:0]                        stat_rx_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [2:0]    cur_beat;
  logic [335:0]  head_q, head_d;
  logic [47:0]   pay_q, pay_d;
  logic [5:0]    pkeep_q, pkeep_d;
  logic          hv_q, hv_d;
  logic          arp_q, arp_d, icmp_q, icmp_d, udp_q, udp_d;
  logic          mv_q, mv_d, ml_q, ml_d;
  logic [63:0]   md_q, md_d;
  logic [7:0]    mk_q, mk_d;
  logic          dst_ok, ipv4_ok, is_arp, is_icmp, is_udp;

  // A beat accepted in IDLE is always beat 0 of a new frame.
  assign cur_beat = (state_q == S_IDLE) ? 3'd0 : beat_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    head_d  = head_q;
    pay_d   = pay_q;
    pkeep_d = pkeep_q;
    hv_d    = 1'b0;
    arp_d   = arp_q;
    icmp_d  = icmp_q;
    udp_d   = udp_q;
    mv_d    = 1'b0;
    md_d    = '0;
    ml_d    = 1'b0;
    mk_d    = '0;
    dst_ok  = 1'b0;
    ipv4_ok = 1'b0;
    is_arp  = 1'b0;
    is_icmp = 1'b0;
    is_udp  = 1'b0;
    if (rx_axis.tvalid) begin
      case (state_q)
        S_IDLE, S_HEAD: begin
          if (state_q == S_IDLE) begin
            arp_d  = 1'b0;
            icmp_d = 1'b0;
            udp_d  = 1'b0;
          end
          for (int i = 0; i < 8; i++) begin
            if (cur_beat != 3'd5 || i < 2)
              head_d[335 - 8*(8*int'(cur_beat) + i) -: 8] = rx_axis.tdata[8*i +: 8];
          end
          if (cur_beat == 3'd5) begin
            pay_d   = rx_axis.tdata[63:16];
            pkeep_d = rx_axis.tkeep[7:2];
            // Field offsets: dst MAC 0..5, ethertype 12..13, ver/IHL 14, ARP op 20..21,
            // proto 23, IPv4 dst 30..33, ICMP type 34, ARP target IP 38..41.
            dst_ok  = (head_d[335:288] == LOCAL_MAC) || (head_d[335:288] == 48'hFFFF_FFFF_FFFF);
            ipv4_ok = (head_d[239:224] == 16'h0800) && (head_d[223:216] == 8'h45) &&
                      (head_d[95:64] == LOCAL_IP);
            is_arp  = (head_d[239:224] == 16'h0806) && (head_d[175:160] == 16'h0001) &&
                      (head_d[31:0] == LOCAL_IP);
            is_icmp = ipv4_ok && (head_d[151:144] == 8'h01) && (head_d[63:56] == 8'h08);
            is_udp  = ipv4_ok && (head_d[151:144] == 8'h11);
            arp_d   = dst_ok && is_arp;
            icmp_d  = dst_ok && is_icmp;
            udp_d   = dst_ok && is_udp;
            hv_d    = arp_d || icmp_d || udp_d;
            beat_d  = 3'd0;
            if (rx_axis.tlast)
              state_d = S_IDLE;
            else
              state_d = hv_d ? S_PAYLOAD : S_DROP;
          end else if (rx_axis.tlast) begin
            state_d = S_IDLE;
            beat_d  = 3'd0;
          end else begin
            state_d = S_HEAD;
            beat_d  = cur_beat + 3'd1;
          end
        end
        S_PAYLOAD: begin
          mv_d = 1'b1;
          md_d = rx_axis.tdata;
          ml_d = rx_axis.tlast;
          mk_d = rx_axis.tkeep;
          if (rx_axis.tlast) state_d = S_IDLE;
        end
        default: begin
          if (rx_axis.tlast) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      head_q  <= '0;
      pay_q   <= '0;
      pkeep_q <= '0;
      hv_q    <= 1'b0;
      arp_q   <= 1'b0;
      icmp_q  <= 1'b0;
      udp_q   <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      ml_q    <= 1'b0;
      mk_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      head_q  <= head_d;
      pay_q   <= pay_d;
      pkeep_q <= pkeep_d;
      hv_q    <= hv_d;
      arp_q   <= arp_d;
      icmp_q  <= icmp_d;
      udp_q   <= udp_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      ml_q    <= ml_d;
      mk_q    <= mk_d;
    end
  end

  assign data_head                    = head_q;
  assign data_head_frame_payload      = pay_q;
  assign data_head_frame_payload_keep = pkeep_q;
  assign data_head_valid              = hv_q;
  assign arp_valid                    = arp_q;
  assign icmp_valid                   = icmp_q;
  assign udp_valid                    = udp_q;
  assign m_axis.tvalid                = mv_q;
  assign m_axis.tdata                 = md_q;
  assign m_axis.tlast                 = ml_q;
  assign m_axis.tkeep                 = mk_q;

`ifdef ETH_RX_STATS_EN
  logic [15:0] frames_q, frames_d, dropped_q, dropped_d;
  logic        drop_ev;

  // Runt (tlast before beat 5) and classification miss both count as one drop.
  always_comb begin
    drop_ev   = 1'b0;
    frames_d  = frames_q;
    dropped_d = dropped_q;
    if (rx_axis.tvalid && (state_q == S_IDLE || state_q == S_HEAD))
      drop_ev = (cur_beat == 3'd5) ? !hv_d : rx_axis.tlast;
    if (hv_d && frames_q != 16'hFFFF) frames_d = frames_q + 16'd1;
    if (drop_ev && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frames_q  <= '0;
      dropped_q <= '0;
    end else begin
      frames_q  <= frames_d;
      dropped_q <= dropped_d;
    end
  end

  assign stat_rx_frames  = frames_q;
  assign stat_rx_dropped = dropped_q;
`else
  assign stat_rx_frames  = 16'd0;
  assign stat_rx_dropped = 16'd0;
`endif

endmodule

// File: tb/tb_ethernet_request_receiver.sv
// tb/tb_ethernet_request_receiver.sv - directed self-checking bench for ethernet_request_receiver
module tb_ethernet_request_receiver;

    localparam logic [47:0] LMAC = 48'h020000000001;
    localparam logic [31:0] LIP  = 32'hC0A80164;

`ifdef ETH_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [335:0]  data_head;
    logic [47:0]   data_head_frame_payload;
    logic [5:0]    data_head_frame_payload_keep;
    logic          data_head_valid, arp_valid, icmp_valid, udp_valid;
    logic [15:0]   stat_rx_frames, stat_rx_dropped;

    ethernet_request_receiver_if rx_if ();
    ethernet_request_receiver_if m_if ();

    ethernet_request_receiver dut (
        .i_clk                        (i_clk),
        .i_reset_n                    (i_reset_n),
        .rx_axis                      (rx_if.slave),
        .data_head                    (data_head),
        .data_head_frame_payload      (data_head_frame_payload),
        .data_head_frame_payload_keep (data_head_frame_payload_keep),
        .data_head_valid              (data_head_valid),
        .arp_valid                    (arp_valid),
        .icmp_valid                   (icmp_valid),
        .udp_valid                    (udp_valid),
        .m_axis                       (m_if.master),
        .stat_rx_frames               (stat_rx_frames),
        .stat_rx_dropped              (stat_rx_dropped)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic fail(input string tag, input logic [335:0] obs, input logic [335:0] exp);
        n_err++;
        $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic [7:0]  fr [0:127];
    int          fr_len;
    logic        dhv_after5;
    logic        m_valid_at_abort, udp_at_abort;

    logic [63:0] m_data_q [$];
    logic [7:0]  m_keep_q [$];
    logic        m_last_q [$];
    int          pulses = 0;

    always @(negedge i_clk) begin
        if (m_if.tvalid) begin
            m_data_q.push_back(m_if.tdata);
            m_keep_q.push_back(m_if.tkeep);
            m_last_q.push_back(m_if.tlast);
        end
        if (data_head_valid) pulses++;
    end

    task automatic fill(input int len);
        for (int i = 0; i < 128; i++) fr[i] = (i < len) ? i[7:0] : 8'h00;
        fr_len = len;
    endtask

    task automatic build_ipv4(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [7:0] proto, input int len);
        fill(len);
        for (int j = 0; j < 6; j++) fr[j] = mac[47-8*j -: 8];
        fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = proto;
        for (int j = 0; j < 4; j++) fr[30+j] = ip[31-8*j -: 8];
        fr[34] = 8'h08;
    endtask

    task automatic build_arp(input logic [47:0] mac, input logic [31:0] ip, input int len);
        fill(len);
        for (int j = 0; j < 6; j++) fr[j] = mac[47-8*j -: 8];
        fr[12] = 8'h08; fr[13] = 8'h06; fr[20] = 8'h00; fr[21] = 8'h01;
        for (int j = 0; j < 4; j++) fr[38+j] = ip[31-8*j -: 8];
    endtask

    function automatic logic [335:0] exp_head();
        logic [335:0] r;
        for (int j = 0; j < 42; j++) r[335-8*j -: 8] = fr[j];
        return r;
    endfunction

    task automatic send(input int gap_beat, input int abort_at);
        int nbeats;
        nbeats = (fr_len + 7) / 8;
        dhv_after5 = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == gap_beat) begin
                rx_if.tvalid = 1'b0;
                repeat (3) begin @(posedge i_clk); #1; end
            end
            if (k == abort_at) begin
                m_valid_at_abort = m_if.tvalid;
                udp_at_abort     = udp_valid;
                i_reset_n        = 1'b0;
                rx_if.tvalid     = 1'b0;
                #1;
                return;
            end
            rx_if.tvalid = 1'b1;
            rx_if.tlast  = (k == nbeats - 1);
            for (int l = 0; l < 8; l++) begin
                rx_if.tdata[8*l +: 8] = (8*k + l < fr_len) ? fr[8*k + l] : 8'h00;
                rx_if.tkeep[l]        = (8*k + l < fr_len);
            end
            @(posedge i_clk); #1;
            if (k == 5) dhv_after5 = data_head_valid;
        end
    endtask

    task automatic idle(input int n);
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tkeep  = '0;
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    int mb, pb;
    logic [335:0] icmp_head;
    logic [335:0] eh;
    logic [15:0]  exp_s;

    initial begin
        i_reset_n    = 1'b0;
        rx_if.tvalid = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tlast  = 1'b0;
        rx_if.tkeep  = '0;
        repeat (3) begin @(posedge i_clk); #1; end
        n_vec++; if (data_head !== 336'd0) fail("rst_head", data_head, 336'd0);
        n_vec++; if (data_head_frame_payload !== 48'd0) fail("rst_payload", data_head_frame_payload, 0);
        n_vec++; if ({data_head_valid, arp_valid, icmp_valid, udp_valid} !== 4'b0000)
            fail("rst_flags", {data_head_valid, arp_valid, icmp_valid, udp_valid}, 0);
        n_vec++; if (m_if.tvalid !== 1'b0) fail("rst_m_tvalid", m_if.tvalid, 0);
        n_vec++; if ({stat_rx_frames, stat_rx_dropped} !== 32'd0)
            fail("rst_stats", {stat_rx_frames, stat_rx_dropped}, 0);
        i_reset_n = 1'b1;
        idle(2);

        build_ipv4(LMAC, LIP, 8'h01, 98);
        mb = m_data_q.size(); pb = pulses;
        send(-1, -1);
        idle(2);
        eh = exp_head();
        n_vec++; if (dhv_after5 !== 1'b1) fail("icmp_dhv_after5", dhv_after5, 1);
        n_vec++; if (pulses - pb != 1) fail("icmp_pulses", pulses - pb, 1);
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b010)
            fail("icmp_flags", {arp_valid, icmp_valid, udp_valid}, 3'b010);
        n_vec++; if (m_data_q.size() - mb != 7) fail("icmp_m_beats", m_data_q.size() - mb, 7);
        n_vec++; if (m_data_q[mb] !== 64'h3736353433323130)
            fail("icmp_m_first", m_data_q[mb], 64'h3736353433323130);
        n_vec++; if (m_data_q[mb+6] !== 64'h0000000000006160)
            fail("icmp_m_last_data", m_data_q[mb+6], 64'h0000000000006160);
        n_vec++; if (m_keep_q[mb+6] !== 8'h03) fail("icmp_m_last_keep", m_keep_q[mb+6], 8'h03);
        n_vec++; if (m_last_q[mb+6] !== 1'b1) fail("icmp_m_last_tlast", m_last_q[mb+6], 1);
        n_vec++; if (data_head !== eh) fail("icmp_head", data_head, eh);
        n_vec++; if (data_head[335:288] !== 48'h020000000001)
            fail("icmp_head_dmac", data_head[335:288], 48'h020000000001);
        n_vec++; if (data_head_frame_payload !== 48'h2F2E2D2C2B2A)
            fail("icmp_payload", data_head_frame_payload, 48'h2F2E2D2C2B2A);
        n_vec++; if (data_head_frame_payload_keep !== 6'h3F)
            fail("icmp_payload_keep", data_head_frame_payload_keep, 6'h3F);
        n_vec++; if (m_if.tdata !== 64'd0) fail("idle_m_tdata", m_if.tdata, 0);
        icmp_head = data_head;

        build_arp(48'hFFFFFFFFFFFF, LIP, 64);
        mb = m_data_q.size();
        send(-1, -1);
        idle(2);
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b100)
            fail("arp_flags", {arp_valid, icmp_valid, udp_valid}, 3'b100);
        n_vec++; if (data_head[239:224] !== 16'h0806)
            fail("arp_ethertype", data_head[239:224], 16'h0806);
        n_vec++; if (m_data_q.size() - mb != 2) fail("arp_m_beats", m_data_q.size() - mb, 2);
        n_vec++; if (m_data_q[mb+1] !== 64'h3F3E3D3C3B3A3938)
            fail("arp_m_last_data", m_data_q[mb+1], 64'h3F3E3D3C3B3A3938);
        n_vec++; if (m_keep_q[mb+1] !== 8'hFF) fail("arp_m_last_keep", m_keep_q[mb+1], 8'hFF);

        build_ipv4(LMAC, 32'hC0A80107, 8'h11, 80);
        mb = m_data_q.size(); pb = pulses;
        send(-1, -1);
        idle(2);
        n_vec++; if (pulses - pb != 0) fail("udp_bad_pulses", pulses - pb, 0);
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b000)
            fail("udp_bad_flags", {arp_valid, icmp_valid, udp_valid}, 0);
        n_vec++; if (m_data_q.size() - mb != 0) fail("udp_bad_m_beats", m_data_q.size() - mb, 0);
        exp_s = (STATS != 0) ? 16'd1 : 16'd0;
        n_vec++; if (stat_rx_dropped !== exp_s) fail("udp_bad_dropped", stat_rx_dropped, exp_s);
        exp_s = (STATS != 0) ? 16'd2 : 16'd0;
        n_vec++; if (stat_rx_frames !== exp_s) fail("udp_bad_frames", stat_rx_frames, exp_s);

        build_ipv4(LMAC, LIP, 8'h01, 32);
        mb = m_data_q.size(); pb = pulses;
        send(-1, -1);
        n_vec++; if (data_head_valid !== 1'b0) fail("runt_dhv", data_head_valid, 0);
        build_ipv4(LMAC, LIP, 8'h01, 98);
        send(-1, -1);
        idle(2);
        n_vec++; if (pulses - pb != 1) fail("b2b_pulses", pulses - pb, 1);
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b010)
            fail("b2b_flags", {arp_valid, icmp_valid, udp_valid}, 3'b010);
        n_vec++; if (m_data_q.size() - mb != 7) fail("b2b_m_beats", m_data_q.size() - mb, 7);
        exp_s = (STATS != 0) ? 16'd2 : 16'd0;
        n_vec++; if (stat_rx_dropped !== exp_s) fail("b2b_dropped", stat_rx_dropped, exp_s);
        exp_s = (STATS != 0) ? 16'd3 : 16'd0;
        n_vec++; if (stat_rx_frames !== exp_s) fail("b2b_frames", stat_rx_frames, exp_s);

        build_ipv4(LMAC, LIP, 8'h01, 98);
        send(3, -1);
        idle(2);
        n_vec++; if (dhv_after5 !== 1'b1) fail("gap_dhv_after5", dhv_after5, 1);
        n_vec++; if (data_head !== icmp_head) fail("gap_head", data_head, icmp_head);
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b010)
            fail("gap_flags", {arp_valid, icmp_valid, udp_valid}, 3'b010);

        build_ipv4(LMAC, LIP, 8'h11, 96);
        send(-1, 7);
        n_vec++; if (m_valid_at_abort !== 1'b1) fail("abort_m_valid_before", m_valid_at_abort, 1);
        n_vec++; if (udp_at_abort !== 1'b1) fail("abort_udp_before", udp_at_abort, 1);
        n_vec++; if ({data_head_valid, arp_valid, icmp_valid, udp_valid} !== 4'b0000)
            fail("abort_flags", {data_head_valid, arp_valid, icmp_valid, udp_valid}, 0);
        n_vec++; if (data_head !== 336'd0) fail("abort_head", data_head, 0);
        n_vec++; if (m_if.tvalid !== 1'b0) fail("abort_m_tvalid", m_if.tvalid, 0);
        n_vec++; if ({stat_rx_frames, stat_rx_dropped} !== 32'd0)
            fail("abort_stats", {stat_rx_frames, stat_rx_dropped}, 0);
        idle(2);
        i_reset_n = 1'b1;
        idle(1);
        build_ipv4(LMAC, LIP, 8'h01, 98);
        mb = m_data_q.size();
        send(-1, -1);
        idle(2);
        eh = exp_head();
        n_vec++; if ({arp_valid, icmp_valid, udp_valid} !== 3'b010)
            fail("post_rst_flags", {arp_valid, icmp_valid, udp_valid}, 3'b010);
        n_vec++; if (data_head !== eh) fail("post_rst_head", data_head, eh);
        n_vec++; if (m_data_q.size() - mb != 7) fail("post_rst_m_beats", m_data_q.size() - mb, 7);
        exp_s = (STATS != 0) ? 16'd1 : 16'd0;
        n_vec++; if (stat_rx_frames !== exp_s) fail("post_rst_frames", stat_rx_frames, exp_s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
